// File: rtl/alu_responder.sv
// alu_responder: single-register ALU request stage feeding a result FIFO,
// with valid/ready handshakes on both sides and a delivered-result counter.
module alu_responder #(
   parameter int WIDTH      = 32,
   parameter int FIFO_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [WIDTH-1:0] req_x,
   input  logic [WIDTH-1:0] req_y,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_z,
   output logic             rsp_zero,
   output logic             rsp_err,
   output logic [15:0]      rsp_count
);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef struct packed {
      logic [WIDTH-1:0] z;
      logic             zero;
      logic             err;
   } entry_t;

   logic             r_s1_valid;
   logic [2:0]       r_s1_op;
   logic [WIDTH-1:0] r_s1_x;
   logic [WIDTH-1:0] r_s1_y;
   entry_t           r_mem [FIFO_DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic [15:0]      r_rsp_count;
   logic             w_full;
   logic             w_push;
   logic             w_pop;
   logic             w_req_xfer;
   logic [WIDTH-1:0] w_z;
   entry_t           w_res;
   entry_t           w_head;

   always_comb begin
      w_z = '0;
      case (r_s1_op)
         3'b000:  w_z = r_s1_x & r_s1_y;
         3'b001:  w_z = r_s1_x | r_s1_y;
         3'b010:  w_z = r_s1_x ^ r_s1_y;
         3'b011:  w_z = ~(r_s1_x | r_s1_y);
         3'b100:  w_z = r_s1_x + r_s1_y;
         3'b101:  w_z = r_s1_x - r_s1_y;
         3'b110:  w_z = {{(WIDTH-1){1'b0}}, $signed(r_s1_x) < $signed(r_s1_y)};
         default: w_z = '0;
      endcase
   end

   assign w_res      = {w_z, ~|w_z, &r_s1_op};
   assign w_full     = r_count == (AW+1)'(FIFO_DEPTH);
   assign rsp_valid  = r_count != '0;
   assign w_pop      = rsp_valid && rsp_ready;
   // A full FIFO still accepts S1 when its head leaves in the same cycle
   assign w_push     = r_s1_valid && (!w_full || w_pop);
   assign req_ready  = !r_s1_valid || w_push;
   assign w_req_xfer = req_valid && req_ready;
   assign w_head     = r_mem[r_rd_ptr];
   assign rsp_z      = rsp_valid ? w_head.z : '0;
   assign rsp_zero   = rsp_valid && w_head.zero;
   assign rsp_err    = rsp_valid && w_head.err;
   assign rsp_count  = r_rsp_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
      end else if (w_req_xfer) begin
         r_s1_valid <= 1'b1;
         r_s1_op    <= req_op;
         r_s1_x     <= req_x;
         r_s1_y     <= req_y;
      end else if (w_push) begin
         r_s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_rsp_count <= '0;
      end else begin
         r_wr_ptr    <= w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
         r_rd_ptr    <= w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
         r_count     <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
         r_rsp_count <= w_pop ? r_rsp_count + 16'd1 : r_rsp_count;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_res;
   end
endmodule

// File: tb/tb_alu_responder.sv
// tb_alu_responder: directed checks of alu_responder handshakes, opcodes,
// backpressure, reset, full-rate streaming and counter wrap.
module tb_alu_responder;
   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_x;
   logic [31:0] req_y;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_z;
   logic        rsp_zero;
   logic        rsp_err;
   logic [15:0] rsp_count;

   int          passed;
   int          total;
   int          stalls;
   int          seen;
   int          xfers;
   int          cyc;
   logic [33:0] exp_e;
   logic [33:0] q[$];

   alu_responder #(.WIDTH(32), .FIFO_DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_x(req_x), .req_y(req_y),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_z(rsp_z),
      .rsp_zero(rsp_zero), .rsp_err(rsp_err), .rsp_count(rsp_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Reference result {z, zero, err}; SLT decided from sign bits first
   function automatic logic [33:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
      logic [31:0] z;
      case (op)
         3'd0:    z = x & y;
         3'd1:    z = x | y;
         3'd2:    z = x ^ y;
         3'd3:    z = ~x & ~y;
         3'd4:    z = x + y;
         3'd5:    z = x + ~y + 32'd1;
         3'd6:    z = (x[31] != y[31]) ? {31'd0, x[31]} : {31'd0, x < y};
         default: z = 32'd0;
      endcase
      return {z, z == 32'd0, op == 3'd7};
   endfunction

   task automatic one(input string tag, input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] ez, input logic ezero, input logic eerr);
      req_valid = 1'b1; req_op = op; req_x = x; req_y = y;
      tick;
      req_valid = 1'b0;
      tick;
      chk({tag, "_valid"}, rsp_valid, 1'b1);
      chk({tag, "_z"}, rsp_z, ez);
      chk({tag, "_zero"}, rsp_zero, ezero);
      chk({tag, "_err"}, rsp_err, eerr);
      tick;
   endtask

   task automatic run_to(input int n);
      while (xfers < n && cyc < 70000) begin
         if (rsp_valid) xfers++;
         tick;
         cyc++;
      end
   endtask

   initial begin
      passed = 0; total = 0;
      rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_x = '0; req_y = '0; rsp_ready = 1'b0;
      tick;
      req_valid = 1'b1;
      tick;
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_z", rsp_z, 32'd0);
      chk("rst_zero", rsp_zero, 1'b0);
      chk("rst_err", rsp_err, 1'b0);
      chk("rst_count", rsp_count, 16'd0);
      req_valid = 1'b0; rst = 1'b0;
      tick;
      chk("rst_no_accept", rsp_valid, 1'b0);

      // XOR latency: accepted at edge N, visible after edge N+1
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_op = 3'b010; req_x = 32'h3; req_y = 32'h5;
      tick;
      req_valid = 1'b0;
      chk("xor_early", rsp_valid, 1'b0);
      tick;
      chk("xor_valid", rsp_valid, 1'b1);
      chk("xor_z", rsp_z, 32'h6);
      chk("xor_zero", rsp_zero, 1'b0);
      chk("xor_err", rsp_err, 1'b0);
      tick;
      chk("xor_count", rsp_count, 16'd1);
      chk("xor_drained", rsp_valid, 1'b0);

      one("add_wrap", 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0);
      one("sub", 3'b101, 32'h5, 32'h7, 32'hFFFF_FFFE, 1'b0, 1'b0);
      one("slt", 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b0);
      one("slt_neg", 3'b110, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
      one("nor", 3'b011, 32'hF0F0_0000, 32'h0F0F_0000, 32'h0000_FFFF, 1'b0, 1'b0);
      one("illegal", 3'b111, 32'h1234, 32'h5678, 32'h0, 1'b1, 1'b1);
      chk("arith_count", rsp_count, 16'd7);

      // Backpressure: three requests fill S1 plus two FIFO entries
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_op = 3'b100; req_y = 32'd10;
      req_x = 32'd1;
      tick;
      req_x = 32'd2;
      chk("bp_ready_b", req_ready, 1'b1);
      tick;
      req_x = 32'd3;
      chk("bp_ready_c", req_ready, 1'b1);
      tick;
      req_x = 32'd4;
      chk("bp_ready_d", req_ready, 1'b0);
      tick;
      chk("bp_stall", req_ready, 1'b0);
      chk("bp_head", rsp_z, 32'd11);
      tick;
      chk("bp_hold", rsp_z, 32'd11);
      chk("bp_hold_valid", rsp_valid, 1'b1);
      rsp_ready = 1'b1;
      #1;
      chk("bp_release_ready", req_ready, 1'b1);
      tick;
      req_valid = 1'b0;
      chk("bp_r2", rsp_z, 32'd12);
      tick;
      chk("bp_r3", rsp_z, 32'd13);
      tick;
      chk("bp_r4", rsp_z, 32'd14);
      chk("bp_r4_valid", rsp_valid, 1'b1);
      tick;
      chk("bp_empty", rsp_valid, 1'b0);

      // Reset with two buffered results and a request on the same edge
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_op = 3'b000; req_x = 32'hFF; req_y = 32'h0F;
      tick;
      req_x = 32'hF0;
      tick;
      req_valid = 1'b0;
      tick;
      chk("mid_full", rsp_valid, 1'b1);
      rst = 1'b1; req_valid = 1'b1;
      tick;
      chk("mid_valid", rsp_valid, 1'b0);
      chk("mid_count", rsp_count, 16'd0);
      chk("mid_ready", req_ready, 1'b1);
      chk("mid_z", rsp_z, 32'd0);
      rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
      tick;
      tick;
      tick;
      chk("mid_no_stale", rsp_valid, 1'b0);
      chk("mid_count_hold", rsp_count, 16'd0);

      // Full-rate stream of 100 random requests against the model
      stalls = 0; seen = 0; q.delete();
      for (int i = 0; i < 104; i++) begin
         if (i < 100) begin
            req_valid = 1'b1;
            req_op = 3'($urandom_range(0, 7));
            req_x = $urandom;
            req_y = $urandom;
         end else begin
            req_valid = 1'b0;
         end
         #1;
         if (i < 100 && !req_ready) stalls++;
         if (rsp_valid) begin
            chk("tp_have_expected", q.size() != 0, 1'b1);
            if (q.size() != 0) begin
               exp_e = q.pop_front();
               chk("tp_z", rsp_z, exp_e[33:2]);
               chk("tp_zero", rsp_zero, exp_e[1]);
               chk("tp_err", rsp_err, exp_e[0]);
            end
            seen++;
         end
         if (req_valid && req_ready) q.push_back(model(req_op, req_x, req_y));
         tick;
      end
      chk("tp_seen", seen, 100);
      chk("tp_stalls", stalls, 0);
      chk("tp_count", rsp_count, 16'd100);
      chk("tp_leftover", q.size(), 0);

      // Counter wrap after 65536 transfers
      rst = 1'b1;
      tick;
      rst = 1'b0;
      req_valid = 1'b1; req_op = 3'b000; req_x = '0; req_y = '0; rsp_ready = 1'b1;
      xfers = 0; cyc = 0;
      run_to(65535);
      chk("wrap_bound_a", xfers, 65535);
      chk("wrap_ffff", rsp_count, 16'hFFFF);
      run_to(65536);
      chk("wrap_bound_b", xfers, 65536);
      chk("wrap_zero", rsp_count, 16'd0);
      req_valid = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
